instr_fetch_unit: RTL and testbench

- Front end of the 16-bit pipelined datapath. Drives a word-addressed synchronous instruction memory and produces the IF/ID instruction register.
- Consumes the decode stage's hazard, redirect (branch/jump) and halt outputs.
- Includes a one-entry skid buffer so stalls never lose an in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: front end of the 16-bit pipelined datapath.
//   Drives a word-addressed synchronous instruction memory (one-cycle read
//   latency) and produces the IF/ID instruction register. A one-entry skid
//   buffer catches the word that is already in flight when decode stalls.
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   imem_rd_en/addr    read request / address to instruction memory
//   imem_data          instruction word, valid one cycle after a request
//   hazard_detected    decode stall, hold IF/ID
//   redirect_valid/pc  taken branch or jump and its target
//   halt               stop fetching until reset
//   instruction, instr_valid, pc_out   IF/ID register contents
//   flush              one-cycle pulse after a redirect squash
//   halted             unit is in HALTED
module instr_fetch_unit #(
  parameter int unsigned   PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_rd_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  input  logic                hazard_detected,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  output logic [15:0]         instruction,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                flush,
  output logic                halted
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]          state_q,       state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
  logic                req_valid_q,   req_valid_d;
  logic [PC_WIDTH-1:0] req_pc_q,      req_pc_d;
  logic                skid_valid_q,  skid_valid_d;
  logic [15:0]         skid_data_q,   skid_data_d;
  logic [PC_WIDTH-1:0] skid_pc_q,     skid_pc_d;
  logic [15:0]         instr_q,       instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [PC_WIDTH-1:0] pc_out_q,      pc_out_d;
  logic                flush_q,       flush_d;
  logic                halted_q,      halted_d;

  logic run;

  assign run        = (state_q == RUN);
  assign imem_rd_en = run && !hazard_detected && !skid_valid_q &&
                      !redirect_valid && !halt;
  assign imem_addr  = fetch_pc_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_valid_d   = req_valid_q;
    req_pc_d      = req_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    flush_d       = 1'b0;
    halted_d      = halted_q;

    if (run) begin
      if (halt) begin
        // Halt wins over a simultaneous redirect or stall.
        state_d       = HALTED;
        halted_d      = 1'b1;
        instr_valid_d = 1'b0;
        req_valid_d   = 1'b0;
        skid_valid_d  = 1'b0;
      end else if (redirect_valid) begin
        // Squash everything younger; any response this cycle is dropped.
        fetch_pc_d    = redirect_pc;
        req_valid_d   = 1'b0;
        skid_valid_d  = 1'b0;
        instr_valid_d = 1'b0;
        flush_d       = 1'b1;
      end else begin
        if (imem_rd_en) begin
          fetch_pc_d  = fetch_pc_q + 1'b1;
          req_pc_d    = fetch_pc_q;
          req_valid_d = 1'b1;
        end else begin
          req_valid_d = 1'b0;
        end

        if (hazard_detected) begin
          // No request is issued while stalled or while the skid is full,
          // so the skid can never be asked to hold a second word.
          if (req_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = imem_data;
            skid_pc_d    = req_pc_q;
          end
        end else if (skid_valid_q) begin
          instr_d       = skid_data_q;
          pc_out_d      = skid_pc_q;
          instr_valid_d = 1'b1;
          skid_valid_d  = 1'b0;
        end else if (req_valid_q) begin
          instr_d       = imem_data;
          pc_out_d      = req_pc_q;
          instr_valid_d = 1'b1;
        end else begin
          instr_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= '0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign flush       = flush_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit with a
// synchronous one-cycle-latency instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        hazard_detected;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic        flush;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_rd_en      (imem_rd_en),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .hazard_detected (hazard_detected),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .pc_out          (pc_out),
    .flush           (flush),
    .halted          (halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'hF123;
      16'h0001: mem_word = 16'hB456;
      16'h0002: mem_word = 16'h8789;
      16'h0003: mem_word = 16'h5A0B;
      default:  mem_word = a ^ 16'hC3C3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins,
                          input logic [15:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, {16'd0, instruction}, {16'd0, ins});
    chk({tag, "_pc"},    {16'd0, pc_out},      {16'd0, pc});
  endtask

  initial begin
    rst_n = 1'b0; hazard_detected = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0; imem_data = '0;
    tick(); tick();
    chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  {16'd0, instruction}, 32'd0);
    chk("rst_pc",     {16'd0, pc_out}, 32'd0);
    chk("rst_flush",  {31'd0, flush}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr",   {16'd0, imem_addr}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_rd_en", {31'd0, imem_rd_en}, 32'd1);

    // Sequential fetch
    tick();  // edge 1: request 0 issued
    chk("e1_valid", {31'd0, instr_valid}, 32'd0);
    chk("e1_addr",  {16'd0, imem_addr}, 32'd1);
    tick();  chk_ifid("seq0", 16'hF123, 16'h0000);
    chk("e2_addr",  {16'd0, imem_addr}, 32'd2);
    tick();  chk_ifid("seq1", 16'hB456, 16'h0001);

    // Stall for 3 cycles with word 2 in flight
    hazard_detected = 1'b1;
    #1;
    chk("stall_rd_en", {31'd0, imem_rd_en}, 32'd0);
    tick();  chk_ifid("stall_a", 16'hB456, 16'h0001);
    tick();  chk_ifid("stall_b", 16'hB456, 16'h0001);
    tick();  chk_ifid("stall_c", 16'hB456, 16'h0001);
    chk("stall_rd_en2", {31'd0, imem_rd_en}, 32'd0);
    hazard_detected = 1'b0;
    #1;
    chk("drain_rd_en", {31'd0, imem_rd_en}, 32'd0);
    tick();  chk_ifid("drain", 16'h8789, 16'h0002);
    chk("resume_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("resume_addr",  {16'd0, imem_addr}, 32'd3);
    tick();
    chk("bubble_valid", {31'd0, instr_valid}, 32'd0);
    tick();  chk_ifid("seq3", 16'h5A0B, 16'h0003);

    // Redirect to 0x0040
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("redir_rd_en", {31'd0, imem_rd_en}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush", {31'd0, flush}, 32'd1);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr",  {16'd0, imem_addr}, 32'h40);
    tick();
    chk("redir_flush_off", {31'd0, flush}, 32'd0);
    chk("redir_valid2",    {31'd0, instr_valid}, 32'd0);
    tick();  chk_ifid("redir_tgt", 16'hC383, 16'h0040);

    // Redirect + stall with the skid full
    hazard_detected = 1'b1;
    tick();  chk_ifid("skid_hold", 16'hC383, 16'h0040);
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect_valid = 1'b0; hazard_detected = 1'b0;
    chk("rs_flush", {31'd0, flush}, 32'd1);
    chk("rs_valid", {31'd0, instr_valid}, 32'd0);
    chk("rs_addr",  {16'd0, imem_addr}, 32'h80);
    tick();
    chk("rs_skid_dropped", {31'd0, instr_valid}, 32'd0);
    tick();  chk_ifid("rs_tgt", 16'hC343, 16'h0080);

    // Wrap at 0xFFFF
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr0", {16'd0, imem_addr}, 32'hFFFF);
    tick();
    chk("wrap_addr1", {16'd0, imem_addr}, 32'h0000);
    tick();  chk_ifid("wrap_ffff", 16'h3C3C, 16'hFFFF);
    tick();  chk_ifid("wrap_0000", 16'hF123, 16'h0000);

    // Halt beats a simultaneous redirect
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    #1;
    chk("halt_rd_en", {31'd0, imem_rd_en}, 32'd0);
    tick();
    halt = 1'b0;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid",  {31'd0, instr_valid}, 32'd0);
    chk("halt_flush",  {31'd0, flush}, 32'd0);
    chk("halt_addr",   {16'd0, imem_addr}, 32'd2);
    hazard_detected = 1'b1;
    tick();
    hazard_detected = 1'b0;
    tick(); tick();
    chk("halted_stay",  {31'd0, halted}, 32'd1);
    chk("halted_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("halted_valid", {31'd0, instr_valid}, 32'd0);
    chk("halted_flush", {31'd0, flush}, 32'd0);
    chk("halted_addr",  {16'd0, imem_addr}, 32'd2);
    redirect_valid = 1'b0;

    // Reset pulse restarts at RESET_PC
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_addr",   {16'd0, imem_addr}, 32'd0);
    chk("rst2_rd_en",  {31'd0, imem_rd_en}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_e1_valid", {31'd0, instr_valid}, 32'd0);
    tick();  chk_ifid("rst2_seq0", 16'hF123, 16'h0000);
    tick();  chk_ifid("rst2_seq1", 16'hB456, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
